// File: rtl/post_adder_acc_if.sv
// Bus bundle for the DSP48A1 post-adder/accumulator output stage.
interface post_adder_acc_if #(
  parameter int unsigned WIDTH = 48
);
  logic             CEP;
  logic             CECARRY;
  logic [WIDTH-1:0] X_in;
  logic [WIDTH-1:0] C_in;
  logic [WIDTH-1:0] PCIN;
  logic [1:0]       Z_sel;
  logic             Sub;
  logic             CIN;
  logic             Clr_ovf;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] PCOUT;
  logic             CARRYOUT;
  logic             CARRYOUTF;
  logic             OVF;

  // Driver side: operands and controls out, results in.
  modport master (
    output CEP, CECARRY, X_in, C_in, PCIN, Z_sel, Sub, CIN, Clr_ovf,
    input  P, PCOUT, CARRYOUT, CARRYOUTF, OVF
  );

  // Stage side: operands and controls in, results out.
  modport slave (
    input  CEP, CECARRY, X_in, C_in, PCIN, Z_sel, Sub, CIN, Clr_ovf,
    output P, PCOUT, CARRYOUT, CARRYOUTF, OVF
  );
endinterface

// File: rtl/post_adder_acc.sv
// DSP48A1 output stage: Z mux, 48-bit post-add/subtract with accumulate
// feedback, P/CARRYOUT registers, PCOUT cascade and sticky signed overflow.
module post_adder_acc #(
  parameter bit          PREG        = 1'b1,
  parameter bit          CARRYOUTREG = 1'b1,
  parameter int unsigned WIDTH       = 48
) (
  input logic             Clk,
  input logic             Rst,
  post_adder_acc_if.slave bus
);

  localparam int unsigned SUMW = WIDTH + 1;
  localparam int unsigned MSB  = WIDTH - 1;

  logic [WIDTH-1:0] r_p;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_z;
  logic [SUMW-1:0]  w_z_ext;
  logic [SUMW-1:0]  w_x_ext;
  logic [SUMW-1:0]  w_cin_ext;
  logic [SUMW-1:0]  w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  // Z operand select; code 2 always feeds back the P register, even when
  // the P output itself is bypassed.
  always_comb begin
    w_z = '0;
    case (bus.Z_sel)
      2'd0:    w_z = '0;
      2'd1:    w_z = bus.PCIN;
      2'd2:    w_z = r_p;
      2'd3:    w_z = bus.C_in;
      default: w_z = '0;
    endcase
  end

  assign w_z_ext   = SUMW'(w_z);
  assign w_x_ext   = SUMW'(bus.X_in);
  assign w_cin_ext = SUMW'(bus.CIN);

  // One-bit-wider adder; the top bit is carry on add and borrow on subtract.
  always_comb begin
    w_sum = '0;
    if (bus.Sub) begin
      w_sum = w_z_ext - (w_x_ext + w_cin_ext);
    end else begin
      w_sum = w_z_ext + w_x_ext + w_cin_ext;
    end
  end

  assign w_res   = w_sum[WIDTH-1:0];
  assign w_carry = w_sum[WIDTH];

  // Signed overflow on the WIDTH-bit two's-complement view of the operands.
  always_comb begin
    w_ovf = 1'b0;
    if (bus.Sub) begin
      w_ovf = (bus.X_in[MSB] != w_z[MSB]) && (w_res[MSB] != w_z[MSB]);
    end else begin
      w_ovf = (bus.X_in[MSB] == w_z[MSB]) && (w_res[MSB] != w_z[MSB]);
    end
  end

  // P / accumulator feedback register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_p <= '0;
    end else if (bus.CEP) begin
      r_p <= w_res;
    end
  end

  // Carry-out register, independently enabled.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_carry <= 1'b0;
    end else if (bus.CECARRY) begin
      r_carry <= w_carry;
    end
  end

  // Sticky overflow: a new overflow on a CEP edge beats a concurrent clear.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ovf <= 1'b0;
    end else if (bus.CEP && w_ovf) begin
      r_ovf <= 1'b1;
    end else if (bus.Clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // Output selection between registered and combinational paths.
  if (PREG) begin : g_p_reg
    assign bus.P = r_p;
  end else begin : g_p_comb
    assign bus.P = w_res;
  end

  if (CARRYOUTREG) begin : g_co_reg
    assign bus.CARRYOUT = r_carry;
  end else begin : g_co_comb
    assign bus.CARRYOUT = w_carry;
  end

  assign bus.PCOUT     = bus.P;
  assign bus.CARRYOUTF = bus.CARRYOUT;
  assign bus.OVF       = r_ovf;

endmodule
